// File: rtl/fft_input_serializer_pkg.sv
// -----------------------------------------------------------------------------
// fft_input_serializer_pkg
// Shared FFT types used by the input serializer: the complex sample type that
// flows bit-exact from the frame input to the butterfly outputs, and the
// serializer FSM state encoding.
// -----------------------------------------------------------------------------
package fft_input_serializer_pkg;

   localparam int COEFF_WIDTH   = 16;
   localparam int PRODUCT_WIDTH = 2 * COEFF_WIDTH;

   typedef struct packed {
      logic signed [PRODUCT_WIDTH-1:0] re;
      logic signed [PRODUCT_WIDTH-1:0] im;
   } complex_product_t;

   localparam complex_product_t CPLX_ZERO = complex_product_t'({(2 * PRODUCT_WIDTH){1'b0}});

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_STREAM = 1'b1
   } ser_state_e;

endpackage

// File: rtl/fft_input_serializer_if.sv
// -----------------------------------------------------------------------------
// fft_input_serializer_if
// Bundles the frame-input handshake and the butterfly-pair output stream of the
// FFT input serializer.
//   in_valid / in_ready / in_frame : one whole N-sample frame per handshake
//   data_0 / data_1                : butterfly pair x[k], x[k+N/2]
//   out_valid / out_first / out_last : pair qualifiers (out_valid = FFT enable)
// Modports: master = frame producer / stream consumer, slave = serializer.
// -----------------------------------------------------------------------------
interface fft_input_serializer_if #(
   parameter int N = 8
);
   import fft_input_serializer_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   complex_product_t [N-1:0] in_frame;
   complex_product_t       data_0;
   complex_product_t       data_1;
   logic                   out_valid;
   logic                   out_first;
   logic                   out_last;

   modport master (
      output in_valid,
      output in_frame,
      input  in_ready,
      input  data_0,
      input  data_1,
      input  out_valid,
      input  out_first,
      input  out_last
   );

   modport slave (
      input  in_valid,
      input  in_frame,
      output in_ready,
      output data_0,
      output data_1,
      output out_valid,
      output out_first,
      output out_last
   );

endinterface

// File: rtl/fft_input_serializer_frame_bank_pingpong.sv
// -----------------------------------------------------------------------------
// fft_input_serializer_frame_bank_pingpong
// Two-bank frame buffer. A whole frame is written into the bank selected by
// the write pointer; the reader fetches one butterfly pair per cycle from the
// bank selected by the read pointer and releases that bank with a strobe on
// the final pair. Banks are filled and drained strictly in alternation, so the
// write pointer always addresses a free bank whenever in_ready is high.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   i_wr_en, i_wr_frame   : whole-frame write request and data
//   i_release             : current read bank fully streamed, mark it empty
//   i_rd_idx              : pair index k
//   o_in_ready            : at least one bank free (registered flags only)
//   o_rd_full             : read bank holds a frame
//   o_other_full          : the bank after the read bank holds a frame
//   o_rd_data_0/1         : bank[rd_sel][k], bank[rd_sel][k+N/2]
// -----------------------------------------------------------------------------
module fft_input_serializer_frame_bank_pingpong
   import fft_input_serializer_pkg::*;
#(
   parameter  int N         = 8,
   localparam int NUM_PAIRS = N / 2,
   localparam int K_W       = $clog2(NUM_PAIRS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_wr_en,
   input  complex_product_t [N-1:0] i_wr_frame,
   input  logic                     i_release,
   input  logic [K_W-1:0]           i_rd_idx,
   output logic                     o_in_ready,
   output logic                     o_rd_full,
   output logic                     o_other_full,
   output complex_product_t         o_rd_data_0,
   output complex_product_t         o_rd_data_1
);

   complex_product_t r_bank [2][N];
   logic [1:0]       r_full;
   logic             r_wr_sel;
   logic             r_rd_sel;

   logic             w_wr_acc;
   logic             w_rel;
   logic [1:0]       w_set;
   logic [1:0]       w_clr;
   logic [1:0]       w_full_nxt;
   logic [K_W:0]     w_addr_0;
   logic [K_W:0]     w_addr_1;

   // Ready is decoded only from the registered flags: a bank released this
   // cycle becomes writable from the next cycle on.
   assign o_in_ready   = ~(r_full[0] & r_full[1]);
   assign o_rd_full    = r_full[r_rd_sel];
   assign o_other_full = r_full[~r_rd_sel];

   // Qualify the strobes locally so a stray request can never corrupt a bank.
   assign w_wr_acc = i_wr_en & o_in_ready;
   assign w_rel    = i_release & o_rd_full;

   assign w_set      = w_wr_acc ? (r_wr_sel ? 2'b10 : 2'b01) : 2'b00;
   assign w_clr      = w_rel    ? (r_rd_sel ? 2'b10 : 2'b01) : 2'b00;
   assign w_full_nxt = (r_full & ~w_clr) | w_set;

   // Pair k lives in the lower half, its partner k+N/2 in the upper half.
   assign w_addr_0 = {1'b0, i_rd_idx};
   assign w_addr_1 = {1'b1, i_rd_idx};

   assign o_rd_data_0 = r_bank[r_rd_sel][w_addr_0];
   assign o_rd_data_1 = r_bank[r_rd_sel][w_addr_1];

   // Full flags and bank pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_full   <= 2'b00;
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
      end else begin
         r_full <= w_full_nxt;
         if (w_wr_acc) begin
            r_wr_sel <= ~r_wr_sel;
         end
         if (w_rel) begin
            r_rd_sel <= ~r_rd_sel;
         end
      end
   end

   // Frame storage; contents are meaningless until the matching flag is set.
   always_ff @(posedge clk) begin
      if (w_wr_acc) begin
         for (int i = 0; i < N; i++) begin
            r_bank[r_wr_sel][i] <= i_wr_frame[i];
         end
      end
   end

endmodule

// File: rtl/fft_input_serializer.sv
// -----------------------------------------------------------------------------
// fft_input_serializer
// Front-end feeder for the radix-2 pipelined FFT. Accepts whole N-sample
// frames into a ping-pong buffer and streams each as N/2 butterfly pairs
// (x[k], x[k+N/2]). out_valid stays high for an entire frame, and back-to-back
// buffered frames stream with no gap, because the FFT twiddle counter restarts
// whenever its enable drops.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-high; discards all buffered frames
//   bus    : fft_input_serializer_if.slave (frame handshake + pair stream)
// -----------------------------------------------------------------------------
module fft_input_serializer
   import fft_input_serializer_pkg::*;
#(
   parameter  int N         = 8,
   localparam int NUM_PAIRS = N / 2
) (
   input  logic                   clk,
   input  logic                   reset,
   fft_input_serializer_if.slave  bus
);

   localparam int             K_W    = $clog2(NUM_PAIRS);
   localparam logic [K_W-1:0] K_ZERO = K_W'(0);
   localparam logic [K_W-1:0] K_ONE  = K_W'(1);
   localparam logic [K_W-1:0] K_LAST = K_W'(NUM_PAIRS - 1);

   ser_state_e       r_state;
   logic [K_W-1:0]   r_k;
   logic             r_out_valid;
   logic             r_out_first;
   logic             r_out_last;
   complex_product_t r_data_0;
   complex_product_t r_data_1;

   logic             w_in_ready;
   logic             w_rd_full;
   logic             w_other_full;
   logic             w_wr_en;
   logic             w_emit;
   logic             w_release;
   complex_product_t w_rd_data_0;
   complex_product_t w_rd_data_1;

   assign w_wr_en = bus.in_valid & w_in_ready;

   fft_input_serializer_frame_bank_pingpong #(
      .N (N)
   ) u_banks (
      .clk          (clk),
      .reset        (reset),
      .i_wr_en      (w_wr_en),
      .i_wr_frame   (bus.in_frame),
      .i_release    (w_release),
      .i_rd_idx     (r_k),
      .o_in_ready   (w_in_ready),
      .o_rd_full    (w_rd_full),
      .o_other_full (w_other_full),
      .o_rd_data_0  (w_rd_data_0),
      .o_rd_data_1  (w_rd_data_1)
   );

   // A pair is emitted on every STREAM cycle, and also on the IDLE cycle that
   // finds a full bank, so pair 0 appears one edge after the frame lands.
   always_comb begin
      w_emit = 1'b0;
      case (r_state)
         ST_IDLE:   w_emit = w_rd_full;
         ST_STREAM: w_emit = 1'b1;
         default:   w_emit = 1'b0;
      endcase
   end

   assign w_release = w_emit & (r_k == K_LAST);

   // Serializer FSM, pair counter and registered output stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_k         <= K_ZERO;
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_data_0    <= CPLX_ZERO;
         r_data_1    <= CPLX_ZERO;
      end else if (w_emit) begin
         r_data_0    <= w_rd_data_0;
         r_data_1    <= w_rd_data_1;
         r_out_valid <= 1'b1;
         r_out_first <= (r_k == K_ZERO);
         r_out_last  <= (r_k == K_LAST);
         if (w_release) begin
            r_k <= K_ZERO;
            // Only a frame already buffered before this edge continues the
            // run; one landing on this very edge starts a new run from IDLE.
            r_state <= w_other_full ? ST_STREAM : ST_IDLE;
         end else begin
            r_k     <= r_k + K_ONE;
            r_state <= ST_STREAM;
         end
      end else begin
         // data_0/data_1 hold their last values while idle.
         r_out_valid <= 1'b0;
         r_out_first <= 1'b0;
         r_out_last  <= 1'b0;
         r_state     <= ST_IDLE;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.data_0    = r_data_0;
   assign bus.data_1    = r_data_1;
   assign bus.out_valid = r_out_valid;
   assign bus.out_first = r_out_first;
   assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_fft_input_serializer.sv
module tb_fft_input_serializer;
   import fft_input_serializer_pkg::*;

   localparam int N  = 8;
   localparam int NP = N / 2;

   typedef complex_product_t [N-1:0] frame_t;

   typedef struct {
      complex_product_t d0;
      complex_product_t d1;
      logic             first;
      logic             last;
      int               fid;
   } beat_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   fft_input_serializer_if #(.N(N)) bus ();

   fft_input_serializer #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   beat_t  sb[$];
   int     n_cmp    = 0;
   int     n_mis    = 0;
   int     run_len  = 0;
   int     last_run = 0;
   int     frame_id = 0;
   bit     acc;
   frame_t fr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: pair k of a frame is (x[k], x[k+N/2]).
   task automatic push_frame(input frame_t f);
      beat_t b;
      for (int k = 0; k < NP; k++) begin
         b.d0    = f[k];
         b.d1    = f[k + NP];
         b.first = (k == 0);
         b.last  = (k == NP - 1);
         b.fid   = frame_id;
         sb.push_back(b);
      end
      frame_id++;
   endtask

   function automatic frame_t mk_frame(input int base);
      frame_t f;
      for (int i = 0; i < N; i++) begin
         f[i].re = base + i;
         f[i].im = -(base * 16 + i);
      end
      return f;
   endfunction

   // One clock: note acceptance, advance, then check any emitted beat.
   task automatic tick(output bit accepted);
      bit     a;
      beat_t  b;
      frame_t f;
      a = bus.in_valid && bus.in_ready;
      f = bus.in_frame;
      @(posedge clk);
      #1;
      accepted = a && !reset;
      if (reset) begin
         sb.delete();
         run_len = 0;
      end else begin
         if (bus.out_valid) begin
            run_len++;
            chk("beat_pending", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               b = sb.pop_front();
               chk($sformatf("data_0 f%0d", b.fid), bus.data_0, b.d0);
               chk($sformatf("data_1 f%0d", b.fid), bus.data_1, b.d1);
               chk($sformatf("first f%0d", b.fid), bus.out_first, b.first);
               chk($sformatf("last f%0d", b.fid), bus.out_last, b.last);
            end
         end else if (run_len != 0) begin
            chk("run_mult4", run_len % NP, 0);
            last_run = run_len;
            run_len  = 0;
         end
         if (a) push_frame(f);
      end
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (!bus.out_valid && sb.size() == 0) break;
         tick(acc);
      end
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      int cnt;
      int waits;
      int accepted;
      int cyc;

      bus.in_valid = 1'b0;
      bus.in_frame = '0;

      // Reset state
      reset = 1'b1;
      tick(acc);
      tick(acc);
      reset = 1'b0;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_first", bus.out_first, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_data_0", bus.data_0, 0);
      chk("rst_data_1", bus.data_1, 0);
      chk("rst_in_ready", bus.in_ready, 1);

      // Test 1: single frame x[i]=i+1
      for (int i = 0; i < N; i++) begin
         fr[i].re = i + 1;
         fr[i].im = 0;
      end
      bus.in_frame = fr;
      bus.in_valid = 1'b1;
      tick(acc);
      chk("t1_acc", acc, 1);
      bus.in_valid = 1'b0;
      chk("t1_no_zero_lat", bus.out_valid, 0);
      tick(acc);
      chk("t1_valid", bus.out_valid, 1);
      chk("t1_d0_re", bus.data_0.re, 1);
      chk("t1_d1_re", bus.data_1.re, 5);
      chk("t1_first", bus.out_first, 1);
      cnt = 1;
      for (int i = 0; i < 7; i++) begin
         tick(acc);
         cnt += int'(bus.out_valid);
         chk("t1_ready", bus.in_ready, 1);
      end
      chk("t1_beats", cnt, 4);
      chk("t1_sb_empty", sb.size(), 0);

      // Test 2: A, B, C with in_valid held high
      bus.in_valid = 1'b1;
      bus.in_frame = mk_frame(100);
      tick(acc);
      chk("t2_acc_a", acc, 1);
      bus.in_frame = mk_frame(200);
      tick(acc);
      chk("t2_acc_b", acc, 1);
      chk("t2_ready_low", bus.in_ready, 0);
      bus.in_frame = mk_frame(300);
      waits = 0;
      acc   = 1'b0;
      while (!acc && waits < 20) begin
         tick(acc);
         if (!acc) waits++;
      end
      chk("t2_c_wait", waits, 3);
      bus.in_valid = 1'b0;
      drain("t2_drain");
      chk("t2_run", last_run, 12);

      // Test 3: frame accepted at the end of the final beat -> one bubble
      bus.in_frame = mk_frame(400);
      bus.in_valid = 1'b1;
      tick(acc);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) tick(acc);
      chk("t3_last_vis", bus.out_last, 1);
      bus.in_frame = mk_frame(500);
      bus.in_valid = 1'b1;
      tick(acc);
      chk("t3_acc", acc, 1);
      bus.in_valid = 1'b0;
      chk("t3_bubble", bus.out_valid, 0);
      tick(acc);
      chk("t3_resume", bus.out_valid, 1);
      chk("t3_first", bus.out_first, 1);
      drain("t3_drain");
      chk("t3_run", last_run, 4);

      // Test 4: reset mid-frame with the second bank full
      bus.in_frame = mk_frame(600);
      bus.in_valid = 1'b1;
      tick(acc);
      bus.in_frame = mk_frame(700);
      tick(acc);
      chk("t4_acc_h", acc, 1);
      bus.in_valid = 1'b0;
      tick(acc);
      tick(acc);
      chk("t4_streaming", bus.out_valid, 1);
      chk("t4_ready_low", bus.in_ready, 0);
      reset = 1'b1;
      tick(acc);
      reset = 1'b0;
      chk("t4_rst_valid", bus.out_valid, 0);
      chk("t4_rst_ready", bus.in_ready, 1);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick(acc);
         cnt += int'(bus.out_valid);
      end
      chk("t4_no_beats", cnt, 0);
      fr = mk_frame(800);
      bus.in_frame = fr;
      bus.in_valid = 1'b1;
      tick(acc);
      bus.in_valid = 1'b0;
      tick(acc);
      chk("t4_fresh_first", bus.out_first, 1);
      chk("t4_fresh_re", bus.data_0.re, 800);
      drain("t4_drain");
      chk("t4_run", last_run, 4);

      // Test 5: 200 random frames with random valid gaps
      accepted = 0;
      cyc      = 0;
      while (accepted < 200 && cyc < 4000) begin
         bus.in_valid = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) fr[i] = {$urandom, $urandom};
         bus.in_frame = fr;
         tick(acc);
         if (acc) accepted++;
         cyc++;
      end
      chk("t5_accepted", accepted, 200);
      bus.in_valid = 1'b0;
      drain("t5_drain");
      chk("t5_idle_valid", bus.out_valid, 0);
      chk("t5_idle_ready", bus.in_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
